// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the control unit and div_unit.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;
  logic             div_done;
  logic             busy;

  modport master (
    output div_start, dividend, divisor,
    input  hi, lo, div_zero, div_done, busy
  );

  modport slave (
    input  div_start, dividend, divisor,
    output hi, lo, div_zero, div_done, busy
  );
endinterface

// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to lo, remainder to hi,
// one magnitude step per cycle, divide-by-zero reported without touching hi/lo.
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  div_unit_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    ZERO = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic [WIDTH+1:0]   shifted;
  logic [WIDTH+1:0]   trial;
  logic               start_ok;

  assign start_ok = bus.div_start && (bus.divisor != '0);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.div_start) begin
          state_d = (bus.divisor == '0) ? ZERO : CALC;
        end
      end
      CALC: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      ZERO:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    zero_d    = 1'b0;
    done_d    = 1'b0;
    busy_d    = (state_d != IDLE);

    // Remainder is kept below the divisor, so one extra bit of headroom gives a true sign
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {2'b00, dvsr_q};

    case (state_q)
      IDLE: begin
        if (start_ok) begin
          quo_d     = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
          dvsr_d    = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
          neg_quo_d = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
          neg_rem_d = bus.dividend[WIDTH-1];
          rem_d     = '0;
          cnt_d     = CNT_W'(WIDTH);
        end
      end
      CALC: begin
        if (!trial[WIDTH+1]) begin
          rem_d = trial[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q - CNT_W'(1);
      end
      DONE: begin
        lo_d   = neg_quo_q ? -quo_q : quo_q;
        hi_d   = neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        done_d = 1'b1;
      end
      ZERO: begin
        zero_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = zero_q;
  assign bus.div_done = done_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit integer divider for the MIPS multicycle datapath (div instruction).
- Sits downstream of the control unit: the control unit pulses div_start with operands from the A/B registers and waits for div_done.
- Writes quotient to lo and remainder to hi; raises div_zero, which feeds the control unit's divide-by-zero exception input.

Parameters:
- WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- div_start  input  1  start request, sampled only in IDLE.
- dividend  input  WIDTH  signed dividend (rs / A register).
- divisor  input  WIDTH  signed divisor (rt / B register).
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- div_zero  output  1  one-cycle pulse: divide by zero detected.
- div_done  output  1  one-cycle pulse: operation finished (also on div_zero).
- busy  output  1  high while state is not IDLE.

Behaviour:
- Reset (async, any time incl. mid-operation): state=IDLE, hi=0, lo=0, div_zero=0, div_done=0, busy=0; internal counter, remainder and quotient registers cleared; the operation in flight is discarded, with no done pulse.
- States: IDLE, CALC, DONE, ZERO.
- IDLE: div_start=0 -> stay. On div_start=1 at edge E0:
  - divisor==0 -> ZERO.
  - otherwise latch |dividend| and |divisor| as WIDTH-bit unsigned magnitudes, sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend), counter=WIDTH, partial remainder (WIDTH+1 bits)=0 -> CALC.
- CALC: one restoring step per cycle, MSB first:
  - shift {rem, quo} left 1.
  - trial = rem - |divisor|.
  - if trial >= 0: rem=trial, quo LSB=1; else quo LSB=0.
  - counter decrements; the step with counter==1 -> DONE.
  - Exactly WIDTH edges (E1..E_WIDTH) are spent in CALC.
- DONE (entered at E_WIDTH):
  - at edge E_WIDTH+1: lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem (two's complement, truncated to WIDTH); div_done=1; state -> IDLE.
  - div_done is high for exactly the one cycle following E_WIDTH+1, then 0.
  - Total latency: start edge to done-visible = WIDTH+1 edges (33 for WIDTH=32).
- ZERO (entered at E0): at E1 div_zero=1 and div_done=1 for exactly one cycle; hi/lo keep previous values; state -> IDLE.
- busy=1 in CALC, DONE and ZERO; busy=0 in IDLE, including the cycle in which div_done is high.
- div_start while busy: ignored; operands are not re-latched.
- div_start held high continuously: a new operation starts on the first edge in IDLE, i.e. the edge after div_done rises.
- Operand inputs are only sampled at E0; later changes have no effect.
- hi/lo change only on a DONE exit or reset; they hold between operations.
- Rounding: truncation toward zero; remainder takes the dividend's sign; |hi| < |divisor|.
- Overflow case: dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000; no flag raised.
- Magnitude of 0x80000000 is represented as unsigned 0x80000000; there is no overflow in the magnitude path.

Test Plan:
- Reset, then dividend=7, divisor=2, start 1 cycle -> div_done after 33 edges; lo=0x00000003, hi=0x00000001, div_zero=0; busy high for 33 cycles.
- dividend=-7 (0xFFFFFFF9), divisor=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. dividend=7, divisor=-2 -> lo=0xFFFFFFFD, hi=0x00000001. dividend=-7, divisor=-2 -> lo=3, hi=0xFFFFFFFF.
- Preload hi/lo via 100/7 (lo=14, hi=2), then divisor=0 -> div_zero=1 and div_done=1 in the same single cycle, one edge after start; hi=2, lo=14 unchanged.
- dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0. dividend=5, divisor=9 -> lo=0, hi=5.
- Start 100/7; at cycle 10, pulse div_start with 50/5 and change the operands -> ignored; result lo=14, hi=2 at edge 33.
- Start an operation, assert reset asynchronously at cycle 15 -> outputs 0 immediately, no div_done. After release, 9/3 -> lo=3, hi=0 with normal latency.
